// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the multicycle sequencer:
//   - state_t   : FSM state encoding (also driven out on state_o)
//   - ctrl_t    : packed decoder control word, laid out MSB first so a
//                 39-bit ctrl_in casts directly onto it
//   - *_MSB/_LSB/_BIT : bit positions of each control-word field
//   - GP_MUX_MEM: gp_mux_sel value that selects memory data (a load)
//   - is_mem_op : true when an instruction needs the MEM phase
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam int CTRL_W = 39;

    localparam int AF_MSB        = 38;
    localparam int AF_LSB        = 35;
    localparam int I_BIT         = 34;
    localparam int ALU_MUX_BIT   = 33;
    localparam int SHIFT_MSB     = 32;
    localparam int SHIFT_LSB     = 30;
    localparam int CAD_MSB       = 29;
    localparam int CAD_LSB       = 25;
    localparam int GP_WE_BIT     = 24;
    localparam int GP_MUX_MSB    = 23;
    localparam int GP_MUX_LSB    = 22;
    localparam int BF_MSB        = 21;
    localparam int BF_LSB        = 18;
    localparam int PC_MUX_MSB    = 17;
    localparam int PC_MUX_LSB    = 16;
    localparam int MEM_WREN_BIT  = 15;
    localparam int RS_MSB        = 14;
    localparam int RS_LSB        = 10;
    localparam int RT_MSB        = 9;
    localparam int RT_LSB        = 5;
    localparam int RD_MSB        = 4;
    localparam int RD_LSB        = 0;

    localparam logic [1:0] GP_MUX_MEM = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    // Field order matters: the first member is the most significant slice.
    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu_mux_sel;
        logic [2:0] shift_type;
        logic [4:0] cad;
        logic       gp_we;
        logic [1:0] gp_mux_sel;
        logic [3:0] bf;
        logic [1:0] pc_mux_select;
        logic       mem_wren;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ctrl_t;

    // Stores and loads both go through the data-memory phase.
    function automatic logic is_mem_op(input ctrl_t c);
        return c.mem_wren || (c.gp_mux_sel == GP_MUX_MEM);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog
// Counts consecutive cycles spent waiting for a memory acknowledge and flags
// when the wait has lasted TIMEOUT_CYCLES cycles. Only instantiated when
// SEQ_MEM_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock
//   rst_n   in  synchronous active-low reset
//   clear   in  restart the count (asserted on every state change)
//   count   in  one more cycle has passed without an acknowledge
//   expired out this waiting cycle is the TIMEOUT_CYCLES-th one
// ----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // The counter holds the number of waiting cycles already completed, so
    // the cycle in which it equals LAST is the final permitted one.
    assign expired = count && (r_cnt == LAST);

    // Wait-cycle counter; saturates at LAST since the FSM leaves on expiry.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (count && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// The decoder control word is captured at the end of DECODE and all strobes
// are decoded from the state plus that captured copy.
// Optional feature macro: SEQ_MEM_TIMEOUT_EN -- adds a memory-ack watchdog
// that moves the FSM into a sticky FAULT state after TIMEOUT_CYCLES cycles
// without an acknowledge in FETCH or MEM.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   run                 start / continue execution (sampled in IDLE and WB)
//   ctrl_in[38:0]       packed decoder control word (seq_pkg::ctrl_t)
//   imem_ack, dmem_ack  instruction / data memory acknowledges
//   imem_req, ir_load   fetch request, instruction register load
//   alu_en              execute strobe
//   dmem_req, dmem_we   data memory request and write enable
//   gp_we_o, pc_we      register-file write, PC update
//   retire              instruction-retired pulse
//   retired_cnt[31:0]   retired-instruction count (wraps)
//   state_o[2:0]        current state encoding
//   fault               sticky memory-timeout flag
// ----------------------------------------------------------------------------
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [38:0] ctrl_in,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        gp_we_o,
    output logic        pc_we,
    output logic        retire,
    output logic [31:0] retired_cnt,
    output logic [2:0]  state_o,
    output logic        fault
);

    state_t      r_state;
    state_t      w_next_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_retired_cnt;
    logic        w_wd_expired;

    // Only a few fields steer the sequencer; the rest belong to the datapath.
    logic w_unused_ctrl;
    assign w_unused_ctrl = &{1'b0, r_ctrl};

`ifdef SEQ_MEM_TIMEOUT_EN
    logic w_wd_clear;
    logic w_wd_count;
    logic r_fault;

    // Any state change restarts the count, which covers "cleared on entry".
    assign w_wd_clear = (w_next_state != r_state);
    assign w_wd_count = ((r_state == ST_FETCH) && !imem_ack) ||
                        ((r_state == ST_MEM)   && !dmem_ack);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_wd_clear),
        .count  (w_wd_count),
        .expired(w_wd_expired)
    );

    // Sticky fault flag: set on the transition into FAULT, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_next_state == ST_FAULT) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_wd_expired = 1'b0;
    assign fault        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control word is latched once, at the end of DECODE, so EXEC/MEM/WB
    // never see later changes on ctrl_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (r_state == ST_DECODE) begin
            r_ctrl <= ctrl_t'(ctrl_in);
        end
    end

    // Retired-instruction counter; natural 32-bit wraparound.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
        end else if (r_state == ST_WB) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    // Next-state and strobe decode. run is only looked at in IDLE and WB,
    // so an instruction already in flight always completes.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        gp_we_o      = 1'b0;
        pc_we        = 1'b0;
        retire       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                if (imem_ack) begin
                    w_next_state = ST_DECODE;
                end else if (w_wd_expired) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en       = 1'b1;
                w_next_state = is_mem_op(r_ctrl) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = r_ctrl.mem_wren;
                if (dmem_ack) begin
                    w_next_state = ST_WB;
                end else if (w_wd_expired) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_WB: begin
                pc_we        = 1'b1;
                retire       = 1'b1;
                gp_we_o      = r_ctrl.gp_we && (r_ctrl.cad != 5'd0);
                w_next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign retired_cnt = r_retired_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench for multicycle_sequencer. Each instruction is described at
// transaction level (control word, fetch wait, data wait, run level) and
// expanded into the per-cycle outputs the sequencer must produce; a single
// compare process checks every cycle against that expansion. Literal checks
// pin latencies, request lengths and counter values. With SEQ_MEM_TIMEOUT_EN
// defined the DUT is built with TIMEOUT_CYCLES=4 and the timeout is exercised.
// ----------------------------------------------------------------------------
module tb_multicycle_sequencer;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int TbTimeout = 4;
`else
    localparam int TbTimeout = 255;
`endif

    typedef struct packed {
        logic [2:0]  st;
        logic        imemReq;
        logic        irLoad;
        logic        aluEn;
        logic        dmemReq;
        logic        dmemWe;
        logic        gpWe;
        logic        pcWe;
        logic        retire;
        logic [31:0] cnt;
        logic        flt;
    } expVec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [38:0] ctrl_in;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_load;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        gp_we_o;
    logic        pc_we;
    logic        retire;
    logic [31:0] retired_cnt;
    logic [2:0]  state_o;
    logic        fault;

    int          testsRun  = 0;
    int          failCount = 0;
    expVec_t     curExp;
    bit          curValid  = 1'b0;
    logic [31:0] modelCount;
    logic        modelFault;
    int          curLat = 0, lastLat = 0;
    int          curReq = 0, lastReq = 0;
    int          curGp  = 0, lastGp  = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ctrl_in    (ctrl_in),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .alu_en     (alu_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .gp_we_o    (gp_we_o),
        .pc_we      (pc_we),
        .retire     (retire),
        .retired_cnt(retired_cnt),
        .state_o    (state_o),
        .fault      (fault)
    );

    // Per-cycle comparison against the expected vector of the current cycle.
    always @(negedge clk) begin
        expVec_t act;
        if (curValid) begin
            act.st      = state_o;
            act.imemReq = imem_req;
            act.irLoad  = ir_load;
            act.aluEn   = alu_en;
            act.dmemReq = dmem_req;
            act.dmemWe  = dmem_we;
            act.gpWe    = gp_we_o;
            act.pcWe    = pc_we;
            act.retire  = retire;
            act.cnt     = retired_cnt;
            act.flt     = fault;
            testsRun++;
            if (act !== curExp) begin
                failCount++;
                $display("[TB] FAIL cycleVec at %0t: got st=%0d strobes=%b cnt=%0d flt=%b, required st=%0d strobes=%b cnt=%0d flt=%b",
                         $time, act.st,
                         {act.imemReq, act.irLoad, act.aluEn, act.dmemReq, act.dmemWe, act.gpWe, act.pcWe, act.retire},
                         act.cnt, act.flt, curExp.st,
                         {curExp.imemReq, curExp.irLoad, curExp.aluEn, curExp.dmemReq, curExp.dmemWe, curExp.gpWe, curExp.pcWe, curExp.retire},
                         curExp.cnt, curExp.flt);
            end
        end
    end

    // Per-instruction observations: busy cycles, dmem_req cycles, gp writes.
    always @(negedge clk) begin
        if (state_o == 3'd0) begin
            curLat = 0;
            curReq = 0;
            curGp  = 0;
        end else begin
            curLat++;
            if (dmem_req) curReq++;
            if (gp_we_o)  curGp++;
            if (retire) begin
                lastLat = curLat;
                lastReq = curReq;
                lastGp  = curGp;
                curLat  = 0;
                curReq  = 0;
                curGp   = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [38:0] junkCtrl();
        return 39'({$urandom(), $urandom()});
    endfunction

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    function automatic expVec_t mkExp(input logic [2:0] st);
        expVec_t e;
        e     = '0;
        e.st  = st;
        e.cnt = modelCount;
        e.flt = modelFault;
        return e;
    endfunction

    function automatic logic [38:0] mkCtrl(input logic memWren, input logic [1:0] gpMux,
                                           input logic gpWe, input logic [4:0] cad);
        logic [38:0] c;
        c        = junkCtrl();
        c[15]    = memWren;
        c[23:22] = gpMux;
        c[24]    = gpWe;
        c[29:25] = cad;
        return c;
    endfunction

    task automatic applyStimulus(input logic runV, input logic rstV, input logic iAck,
                                 input logic dAck, input logic [38:0] ctrlV, input expVec_t e);
        @(posedge clk);
        #1;
        run      = runV;
        rst_n    = rstV;
        imem_ack = iAck;
        dmem_ack = dAck;
        ctrl_in  = ctrlV;
        curExp   = e;
        curValid = 1'b1;
        @(negedge clk);
        #1;
        curValid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic idleCycle(input logic runV);
        applyStimulus(runV, 1'b1, rb(), rb(), junkCtrl(), mkExp(3'd0));
    endtask

    // Expands one instruction into its cycles. ctrl_in carries the real word
    // only during DECODE and random junk elsewhere; stray acks are random.
    task automatic issueInstr(input logic [38:0] ctrl, input int fetchWait, input int dataWait,
                              input logic runDuring, input logic runAfter, input int resetInMem);
        expVec_t e;
        logic    isMem;
        for (int k = 0; k <= fetchWait; k++) begin
            e         = mkExp(3'd1);
            e.imemReq = 1'b1;
            e.irLoad  = (k == fetchWait);
            applyStimulus(runDuring, 1'b1, (k == fetchWait), rb(), junkCtrl(), e);
        end
        applyStimulus(runDuring, 1'b1, rb(), rb(), ctrl, mkExp(3'd2));
        e       = mkExp(3'd3);
        e.aluEn = 1'b1;
        applyStimulus(runDuring, 1'b1, rb(), rb(), junkCtrl(), e);
        isMem = ctrl[15] | (ctrl[23:22] == 2'b01);
        if (isMem) begin
            for (int k = 0; k <= dataWait; k++) begin
                e         = mkExp(3'd4);
                e.dmemReq = 1'b1;
                e.dmemWe  = ctrl[15];
                if (k == resetInMem) begin
                    applyStimulus(runDuring, 1'b0, rb(), 1'b1, junkCtrl(), e);
                    modelCount = '0;
                    modelFault = 1'b0;
                    return;
                end
                applyStimulus(runDuring, 1'b1, rb(), (k == dataWait), junkCtrl(), e);
            end
        end
        e        = mkExp(3'd5);
        e.pcWe   = 1'b1;
        e.retire = 1'b1;
        e.gpWe   = ctrl[24] && (ctrl[29:25] != 5'd0);
        applyStimulus(runAfter, 1'b1, rb(), rb(), junkCtrl(), e);
        modelCount = modelCount + 32'd1;
    endtask

    initial begin
        expVec_t e;
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        ctrl_in    = '0;
        modelCount = '0;
        modelFault = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, junkCtrl(), mkExp(3'd0));
        checkOutput("resetState", 32'(state_o), 32'd0);
        checkOutput("resetCount", retired_cnt, 32'd0);
        checkOutput("resetFault", 32'(fault), 32'd0);
        idleCycle(1'b0);
        idleCycle(1'b0);

        // ALU op, fetch ack after one wait cycle
        idleCycle(1'b1);
        issueInstr(mkCtrl(1'b0, 2'b00, 1'b1, 5'd5), 1, 0, 1'b1, 1'b0, -1);
        idleCycle(1'b0);
        checkOutput("aluRetiredCnt", retired_cnt, 32'd1);
        checkOutput("aluLatency", lastLat, 32'd5);
        checkOutput("aluGpWrites", lastGp, 32'd1);

        // Store with data ack in the third MEM cycle, back-to-back afterwards
        idleCycle(1'b1);
        issueInstr(mkCtrl(1'b1, 2'b00, 1'b0, 5'd7), 0, 2, 1'b1, 1'b1, -1);
        checkOutput("storeReqCycles", lastReq, 32'd3);
        checkOutput("storeLatency", lastLat, 32'd7);
        checkOutput("storeGpWrites", lastGp, 32'd0);

        // Register write to r0 is suppressed but still retires
        issueInstr(mkCtrl(1'b0, 2'b10, 1'b1, 5'd0), 2, 0, 1'b1, 1'b1, -1);
        checkOutput("cad0GpWrites", lastGp, 32'd0);
        checkOutput("cad0Latency", lastLat, 32'd6);

        // Load (gp_mux_sel=01) takes the MEM phase
        issueInstr(mkCtrl(1'b0, 2'b01, 1'b1, 5'd31), 0, 0, 1'b1, 1'b1, -1);
        checkOutput("loadLatency", lastLat, 32'd5);
        checkOutput("loadReqCycles", lastReq, 32'd1);
        checkOutput("loadGpWrites", lastGp, 32'd1);

        // run low throughout (including MEM): instruction completes, then IDLE
        issueInstr(mkCtrl(1'b1, 2'b11, 1'b1, 5'd3), 1, 3, 1'b0, 1'b0, -1);
        checkOutput("runDropLatency", lastLat, 32'd9);
        checkOutput("runDropReqCycles", lastReq, 32'd4);
        idleCycle(1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);
        checkOutput("runDropRetiredCnt", retired_cnt, 32'd5);
        checkOutput("runDropIdle", 32'(state_o), 32'd0);

        // Reset in MEM together with dmem_ack
        idleCycle(1'b1);
        issueInstr(mkCtrl(1'b0, 2'b01, 1'b1, 5'd9), 1, 5, 1'b1, 1'b0, 1);
        idleCycle(1'b0);
        checkOutput("memResetCnt", retired_cnt, 32'd0);
        checkOutput("memResetState", 32'(state_o), 32'd0);
        checkOutput("memResetReq", 32'(dmem_req), 32'd0);

        // Clean restart after reset
        idleCycle(1'b1);
        issueInstr(mkCtrl(1'b0, 2'b00, 1'b1, 5'd12), 0, 0, 1'b1, 1'b0, -1);
        idleCycle(1'b0);
        checkOutput("restartRetiredCnt", retired_cnt, 32'd1);
        checkOutput("restartLatency", lastLat, 32'd4);

        // Fetch that is never acknowledged
        idleCycle(1'b1);
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            e         = mkExp(3'd1);
            e.imemReq = 1'b1;
            applyStimulus(1'b1, 1'b1, 1'b0, rb(), junkCtrl(), e);
        end
        modelFault = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, junkCtrl(), mkExp(3'd6));
        end
        checkOutput("faultSticky", 32'(fault), 32'd1);
        checkOutput("faultState", 32'(state_o), 32'd6);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, junkCtrl(), mkExp(3'd6));
        modelFault = 1'b0;
        modelCount = '0;
`else
        for (int k = 0; k < 12; k++) begin
            e         = mkExp(3'd1);
            e.imemReq = 1'b1;
            applyStimulus(1'b1, 1'b1, 1'b0, rb(), junkCtrl(), e);
        end
        checkOutput("noTimeoutFault", 32'(fault), 32'd0);
        checkOutput("noTimeoutState", 32'(state_o), 32'd1);
        // Reset mid-FETCH with a coinciding ack: the ack must not advance
        e         = mkExp(3'd1);
        e.imemReq = 1'b1;
        e.irLoad  = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, junkCtrl(), e);
        modelCount = '0;
`endif
        idleCycle(1'b0);
        checkOutput("postResetFault", 32'(fault), 32'd0);
        checkOutput("postResetState", 32'(state_o), 32'd0);
        checkOutput("postResetImemReq", 32'(imem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for any memory ack (used only with SEQ_MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  start/continue execution.
- ctrl_in  in  39  packed decoder control word.
- imem_ack  in  1  instruction memory ack.
- dmem_ack  in  1  data memory ack.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  instruction register load strobe.
- alu_en  out  1  ALU/shift execute strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- gp_we_o  out  1  register-file write enable.
- pc_we  out  1  PC update strobe.
- retire  out  1  instruction-retired pulse.
- retired_cnt  out  32  retired-instruction count.
- state_o  out  3  current FSM state encoding.
- fault  out  1  sticky memory-timeout flag.

Function
REQ-003 ctrl_in layout, MSB first: af[38:35], i[34], alu_mux_sel[33], shift_type[32:30], cad[29:25], gp_we[24], gp_mux_sel[23:22], bf[21:18], pc_mux_select[17:16], mem_wren[15], rs[14:10], rt[9:5], rd[4:0].
REQ-004 FSM states: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6; state_o SHALL equal the encoding.
REQ-005 IDLE: all strobes 0; go to FETCH when run=1.
REQ-006 FETCH: imem_req=1 held until imem_ack=1; in the ack cycle ir_load=1, next state DECODE.
REQ-007 DECODE: one cycle; ctrl_in captured into internal control register at its end; next EXEC.
REQ-008 EXEC: alu_en=1 for exactly one cycle; next MEM if captured mem_wren=1 or gp_mux_sel=2'b01 (load), else WB.
REQ-009 MEM: dmem_req=1, dmem_we=captured mem_wren, both held until dmem_ack=1; next WB.
REQ-010 WB: one cycle; pc_we=1, retire=1, gp_we_o=captured gp_we AND (cad!=0); next FETCH if run=1, else IDLE.
REQ-011 run deassertion SHALL only take effect in IDLE or WB; an in-flight instruction always completes.
REQ-012 retired_cnt SHALL increment by 1 each retire cycle, wrapping 0xFFFFFFFF->0.
REQ-013 Latency: non-memory instruction = 4 cycles + fetch wait; memory instruction = 5 cycles + fetch wait + data wait.
REQ-014 All outputs except retired_cnt, state_o, fault SHALL be combinational decodes of state and captured control only; no output depends combinationally on ctrl_in.

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE, clear control register, retired_cnt=0, fault=0, timeout counter=0; all strobe outputs 0 from the next cycle.
REQ-016 Reset mid-FETCH or mid-MEM SHALL drop the request next cycle; an ack coinciding with reset SHALL be ignored.

Configuration
REQ-017 Macro SEQ_MEM_TIMEOUT_EN defined: counter counts cycles in FETCH/MEM without ack, cleared on state entry; on reaching TIMEOUT_CYCLES enter FAULT, set fault=1.
REQ-018 FAULT: all strobes 0, stays until reset; fault sticky.
REQ-019 Macro undefined: no counter, FAULT unreachable, fault tied 0, waits indefinitely.

Structure
REQ-020 Package seq_pkg SHALL hold the state enum, ctrl_in field bit-position constants, GP_MUX_MEM=2'b01, and control-word struct typedef.
REQ-021 Timeout counter SHALL be sub-module seq_watchdog (inputs clk, rst_n, clear, count; output expired), instantiated only under SEQ_MEM_TIMEOUT_EN.

Verification
REQ-022 ALU op (mem_wren=0, gp_mux_sel=00, gp_we=1, cad=5), imem_ack after 1 cycle -> states 1,2,3,5; gp_we_o=1 and pc_we=1 in WB; retired_cnt=1.
REQ-023 Store (mem_wren=1), dmem_ack after 3 cycles -> dmem_req/dmem_we held 3 cycles, gp_we_o=0 in WB.
REQ-024 gp_we=1, cad=0 -> gp_we_o stays 0; retire still pulses.
REQ-025 run dropped during MEM -> instruction completes, WB then IDLE; no further imem_req.
REQ-026 rst_n=0 in MEM with dmem_ack=1 same cycle -> IDLE, retired_cnt unchanged (0), dmem_req=0 next cycle.
REQ-027 SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ack never -> FAULT after 4 FETCH cycles, fault=1 until reset.
